// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcs_pkg
// Description : Shared types, code-group constants and 8b/10b sub-block
//               encode helpers for the 1000BASE-X PCS receive path.
//               Contents: receive FSM state enum, 10-bit constants for the
//               ordered-set code groups, GMII RXD constants, 5b/6b and
//               3b/4b encode functions used by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package pcs_pkg;

    typedef enum logic [2:0] {
        LINK_FAILED = 3'd0,
        WAIT_FOR_K  = 3'd1,
        RX_K        = 3'd2,
        IDLE_D      = 3'd3,
        RECEIVE     = 3'd4,
        TRI_RRI     = 3'd5
    } pcs_state_t;

    // Code groups, bit a at [9] ... bit j at [0]
    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;
    localparam logic [9:0] D5_6      = 10'b1010010110;
    localparam logic [9:0] D16_2_NEG = 10'b0110110101;
    localparam logic [9:0] D16_2_POS = 10'b1001000101;
    localparam logic [9:0] K27_7_NEG = 10'b1101101000;
    localparam logic [9:0] K27_7_POS = 10'b0010010111;
    localparam logic [9:0] K29_7_NEG = 10'b1011101000;
    localparam logic [9:0] K29_7_POS = 10'b0100010111;
    localparam logic [9:0] K23_7_NEG = 10'b1110101000;
    localparam logic [9:0] K23_7_POS = 10'b0001010111;

    // Decoded octet values
    localparam logic [7:0] OCT_K28_5 = 8'hBC;
    localparam logic [7:0] OCT_K27_7 = 8'hFB;
    localparam logic [7:0] OCT_K29_7 = 8'hFD;
    localparam logic [7:0] OCT_K23_7 = 8'hF7;
    localparam logic [7:0] OCT_D5_6  = 8'hC5;
    localparam logic [7:0] OCT_D16_2 = 8'h50;

    localparam logic [7:0] PREAMBLE      = 8'h55;
    localparam logic [7:0] FALSE_CARRIER = 8'h0E;

    // 5b/6b data code (abcdei) in the RD- column
    function automatic logic [5:0] c6_neg(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // True when the 6b sub-block is unbalanced and therefore flips RD
    function automatic logic disp6(input logic [4:0] x);
        return ($countones(c6_neg(x)) != 3);
    endfunction

    // 6b sub-block for data x under running disparity rd (1 = positive)
    function automatic logic [5:0] enc6(input logic [4:0] x, input logic rd);
        logic [5:0] c;
        c = c6_neg(x);
        if (x == 5'd7) begin
            // D.7 is balanced but still has two spellings
            c = rd ? 6'b000111 : 6'b111000;
        end else if (rd && disp6(x)) begin
            c = ~c;
        end
        return c;
    endfunction

    // 4b sub-block for data y following 6b sub-block x, with rd6 the RD
    // after the 6b sub-block. The alternate D.x.A7 spelling avoids a run of
    // five identical bits across the sub-block boundary.
    function automatic logic [3:0] enc4(input logic [2:0] y, input logic [4:0] x,
                                        input logic rd6);
        logic [3:0] c;
        logic       alt;
        alt = rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                  : (x == 5'd17 || x == 5'd18 || x == 5'd20);
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = alt ? 4'b0111 : 4'b1110;
        endcase
        if (rd6 && (y == 3'd0 || y == 3'd3 || y == 3'd4 || y == 3'd7)) begin
            c = ~c;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_8b10b.sv
`default_nettype none
// ============================================================================
// Module      : decoder_8b10b
// Description : Combinational 8b/10b code-group decoder. Recognises every
//               data group Dx.y plus the control groups K28.5, K27.7, K29.7
//               and K23.7; all other patterns are reported invalid.
// Ports       : code    in  10-bit code group (bit a at [9])
//               rd      in  current running disparity (1 = positive)
//               octet   out decoded octet (0 when invalid)
//               is_k    out group is one of the supported control groups
//               valid   out group exists in either RD column
//               rd_ok   out group belongs to the column selected by rd
//               next_rd out RD after this group (flips on unbalanced group)
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_8b10b
    import pcs_pkg::*;
(
    input  logic [9:0] code,
    input  logic       rd,
    output logic [7:0] octet,
    output logic       is_k,
    output logic       valid,
    output logic       rd_ok,
    output logic       next_rd
);

    // Per assumed incoming RD (index 0 = negative, 1 = positive)
    logic [1:0]      x_hit;
    logic [1:0][4:0] x_found;
    logic [1:0]      rd6;
    logic [1:0]      hit;
    logic [1:0][7:0] cand;

    logic            k_hit;
    logic            k_col;
    logic [7:0]      k_oct;

    // Data decode: search the 6b sub-block, then the 4b sub-block given the
    // RD implied by the 6b sub-block, separately for each assumed input RD.
    always_comb begin
        x_hit   = '0;
        x_found = '0;
        rd6     = '0;
        hit     = '0;
        cand    = '0;
        for (int r = 0; r < 2; r++) begin
            for (int x = 0; x < 32; x++) begin
                if (!x_hit[r] && enc6(5'(x), r[0]) == code[9:4]) begin
                    x_hit[r]   = 1'b1;
                    x_found[r] = 5'(x);
                end
            end
            rd6[r] = r[0] ^ disp6(x_found[r]);
            if (x_hit[r]) begin
                for (int y = 0; y < 8; y++) begin
                    if (!hit[r] && enc4(3'(y), x_found[r], rd6[r]) == code[3:0]) begin
                        hit[r]  = 1'b1;
                        cand[r] = {3'(y), x_found[r]};
                    end
                end
            end
        end
    end

    // Control groups; k_col marks a match in the column for the current RD
    always_comb begin
        k_hit = 1'b0;
        k_col = 1'b0;
        k_oct = '0;
        case (code)
            K28_5_NEG: begin k_hit = 1'b1; k_oct = OCT_K28_5; k_col = ~rd; end
            K28_5_POS: begin k_hit = 1'b1; k_oct = OCT_K28_5; k_col = rd;  end
            K27_7_NEG: begin k_hit = 1'b1; k_oct = OCT_K27_7; k_col = ~rd; end
            K27_7_POS: begin k_hit = 1'b1; k_oct = OCT_K27_7; k_col = rd;  end
            K29_7_NEG: begin k_hit = 1'b1; k_oct = OCT_K29_7; k_col = ~rd; end
            K29_7_POS: begin k_hit = 1'b1; k_oct = OCT_K29_7; k_col = rd;  end
            K23_7_NEG: begin k_hit = 1'b1; k_oct = OCT_K23_7; k_col = ~rd; end
            K23_7_POS: begin k_hit = 1'b1; k_oct = OCT_K23_7; k_col = rd;  end
            default: ;
        endcase
    end

    always_comb begin
        octet = '0;
        is_k  = 1'b0;
        valid = 1'b0;
        rd_ok = 1'b0;
        if (k_hit) begin
            octet = k_oct;
            is_k  = 1'b1;
            valid = 1'b1;
            rd_ok = k_col;
        end else if (hit[rd]) begin
            octet = cand[rd];
            valid = 1'b1;
            rd_ok = 1'b1;
        end else if (hit[~rd]) begin
            octet = cand[~rd];
            valid = 1'b1;
        end
    end

    // RD always follows the group actually received, valid or not
    assign next_rd = rd ^ ($countones(code) != 5);

endmodule
`default_nettype wire

// File: rtl/pcs_receive.sv
`default_nettype none
// ============================================================================
// Module      : pcs_receive
// Description : 1000BASE-X PCS receive state machine. Decodes code groups
//               from the synchronizer, tracks idle / start / data / end
//               delimiters and drives registered GMII receive outputs.
//               Optional macro PCS_RX_DISPARITY_CHECK_EN: when defined, a
//               group received in the wrong RD column is treated as invalid.
// Ports       : clk         in  receive clock
//               reset       in  synchronous active-high reset
//               SUDI        in  {rx_even, code group a..j}
//               sync_status in  synchronizer lock indication
//               RXD         out decoded octet
//               RX_DV       out receive data valid
//               RX_ER       out receive error / false carrier
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_receive
    import pcs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] SUDI,
    input  logic        sync_status,
    output logic [7:0]  RXD,
    output logic        RX_DV,
    output logic        RX_ER
);

    pcs_state_t state;
    logic       rd;

    logic [9:0] code;
    logic       rx_even;
    logic [7:0] dec_octet;
    logic       dec_is_k;
    logic       dec_valid;
    logic       dec_rd_ok;
    logic       dec_next_rd;

    logic       accept;
    logic       is_comma;
    logic       is_sdel;
    logic       is_tdel;
    logic       is_rdel;
    logic       is_idle_d;
    logic       is_data;

    assign code    = SUDI[9:0];
    assign rx_even = SUDI[10];

    decoder_8b10b u_decoder (
        .code    (code),
        .rd      (rd),
        .octet   (dec_octet),
        .is_k    (dec_is_k),
        .valid   (dec_valid),
        .rd_ok   (dec_rd_ok),
        .next_rd (dec_next_rd)
    );

`ifdef PCS_RX_DISPARITY_CHECK_EN
    assign accept = dec_valid & dec_rd_ok;
`else
    // Column membership is informational only in this build
    logic unused_rd_ok;
    assign unused_rd_ok = dec_rd_ok;
    assign accept       = dec_valid;
`endif

    assign is_comma  = accept &  dec_is_k & (dec_octet == OCT_K28_5);
    assign is_sdel   = accept &  dec_is_k & (dec_octet == OCT_K27_7);
    assign is_tdel   = accept &  dec_is_k & (dec_octet == OCT_K29_7);
    assign is_rdel   = accept &  dec_is_k & (dec_octet == OCT_K23_7);
    assign is_idle_d = accept & ~dec_is_k &
                       ((dec_octet == OCT_D5_6) | (dec_octet == OCT_D16_2));
    assign is_data   = accept & ~dec_is_k;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LINK_FAILED;
            rd    <= 1'b0;
            RXD   <= '0;
            RX_DV <= 1'b0;
            RX_ER <= 1'b0;
        end else begin
            RXD   <= '0;
            RX_DV <= 1'b0;
            RX_ER <= 1'b0;
            if (!sync_status) begin
                // Losing sync mid-frame is flagged as an error for one cycle
                if (state == RECEIVE) begin
                    RX_ER <= 1'b1;
                end
                state <= LINK_FAILED;
                rd    <= 1'b0;
            end else begin
                rd <= dec_next_rd;
                case (state)
                    LINK_FAILED: begin
                        state <= WAIT_FOR_K;
                    end
                    WAIT_FOR_K: begin
                        if (is_comma && rx_even) begin
                            state <= RX_K;
                        end
                    end
                    RX_K: begin
                        state <= is_idle_d ? IDLE_D : WAIT_FOR_K;
                    end
                    IDLE_D: begin
                        if (is_comma) begin
                            state <= RX_K;
                        end else if (is_sdel) begin
                            state <= RECEIVE;
                            RXD   <= PREAMBLE;
                            RX_DV <= 1'b1;
                        end else begin
                            // Carrier seen without a valid start delimiter
                            state <= WAIT_FOR_K;
                            RXD   <= FALSE_CARRIER;
                            RX_ER <= 1'b1;
                        end
                    end
                    RECEIVE: begin
                        if (is_tdel) begin
                            state <= TRI_RRI;
                        end else if (is_comma) begin
                            // Frame cut short by an idle
                            state <= RX_K;
                            RX_DV <= 1'b1;
                            RX_ER <= 1'b1;
                        end else if (is_data) begin
                            RXD   <= dec_octet;
                            RX_DV <= 1'b1;
                        end else begin
                            RX_DV <= 1'b1;
                            RX_ER <= 1'b1;
                        end
                    end
                    TRI_RRI: begin
                        if (is_rdel) begin
                            state <= TRI_RRI;
                        end else if (is_comma && rx_even) begin
                            state <= RX_K;
                        end else begin
                            state <= WAIT_FOR_K;
                        end
                    end
                    default: begin
                        state <= LINK_FAILED;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcs_receive.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcs_receive
// Description : Scoreboard testbench for pcs_receive. Stimulus is produced by
//               an 8b/10b transmit encoder; expectations come from a code
//               dictionary built by exhaustive encoding and a frame-level
//               model of the receive rules. A monitor compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_receive;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] SUDI = '0;
    logic        sync_status = 1'b0;
    logic [7:0]  RXD;
    logic        RX_DV;
    logic        RX_ER;

    pcs_receive dut (
        .clk         (clk),
        .reset       (reset),
        .SUDI        (SUDI),
        .sync_status (sync_status),
        .RXD         (RXD),
        .RX_DV       (RX_DV),
        .RX_ER       (RX_ER)
    );

    always #5 clk = ~clk;

    // RD- column 5b/6b codes, D0..D31, and 3b/4b codes D.x.0..D.x.P7
    logic [5:0] c6m [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
        6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
        6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
        6'b011110, 6'b101011};
    logic [3:0] c4m [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                            4'b1101, 4'b1010, 4'b0110, 4'b1110};

    // Code dictionary: code -> octet, control flag, RD columns it lives in
    logic [7:0] m_oct [logic [9:0]];
    bit         m_k   [logic [9:0]];
    bit [1:0]   m_col [logic [9:0]];

    typedef struct packed {
        logic [7:0] rxd;
        logic       dv;
        logic       er;
    } exp_t;
    exp_t exp_q [$];

    int passed = 0;
    int total  = 0;

    bit tx_rd     = 1'b0;
    bit even_flag = 1'b1;
    int cyc       = 0;

    localparam int M_LF = 0, M_WK = 1, M_RK = 2, M_ID = 3, M_RX = 4, M_TR = 5;
    int mst = M_LF;
    bit mrd = 1'b0;

    function automatic logic [9:0] enc10(input logic [7:0] o, input bit k, input bit rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s6;
        logic [3:0] s4;
        bit         rd6;
        bit         unb6;
        x = o[4:0];
        y = o[7:5];
        if (k && o == 8'hBC) begin
            return rd ? 10'b1100000101 : 10'b0011111010;
        end
        unb6 = ($countones(c6m[x]) != 3);
        s6 = (rd && unb6) ? ~c6m[x] : c6m[x];
        if (x == 5'd7 && rd) s6 = 6'b000111;
        rd6 = unb6 ? ~rd : rd;
        if (k) begin
            s4 = rd6 ? 4'b1000 : 4'b0111;
        end else begin
            s4 = c4m[y];
            if (y == 3'd7 && ((!rd6 && (x == 17 || x == 18 || x == 20)) ||
                              (rd6 && (x == 11 || x == 13 || x == 14))))
                s4 = 4'b0111;
            if (rd6 && ($countones(s4) != 2 || y == 3'd3)) s4 = ~s4;
        end
        return {s6, s4};
    endfunction

    task automatic add_entry(input logic [7:0] o, input bit k);
        for (int r = 0; r < 2; r++) begin
            logic [9:0] c;
            bit [1:0]   cm;
            c = enc10(o, k, r[0]);
            cm = m_col.exists(c) ? m_col[c] : 2'b00;
            cm[r] = 1'b1;
            m_oct[c] = o;
            m_k[c]   = k;
            m_col[c] = cm;
        end
    endtask

    // Reference model: one call per consumed code group
    task automatic model(input logic [9:0] c, input bit even, input bit sync, input bit rst);
        exp_t       e;
        bit         acc, kk;
        logic [7:0] o;
        bit [1:0]   cm;
        bit         comma, sdel, tdel, rdel, idle2;
        e = '0;
        if (rst) begin
            mst = M_LF;
            mrd = 1'b0;
        end else begin
            acc = m_oct.exists(c);
            o   = acc ? m_oct[c] : 8'h00;
            kk  = acc ? m_k[c] : 1'b0;
            cm  = acc ? m_col[c] : 2'b00;
`ifdef PCS_RX_DISPARITY_CHECK_EN
            if (!cm[mrd]) acc = 1'b0;
`endif
            comma = acc && kk && o == 8'hBC;
            sdel  = acc && kk && o == 8'hFB;
            tdel  = acc && kk && o == 8'hFD;
            rdel  = acc && kk && o == 8'hF7;
            idle2 = acc && !kk && (o == 8'hC5 || o == 8'h50);
            if (!sync) begin
                if (mst == M_RX) e.er = 1'b1;
                mst = M_LF;
                mrd = 1'b0;
            end else begin
                case (mst)
                    M_LF: mst = M_WK;
                    M_WK: if (comma && even) mst = M_RK;
                    M_RK: mst = idle2 ? M_ID : M_WK;
                    M_ID: begin
                        if (comma) mst = M_RK;
                        else if (sdel) begin e.rxd = 8'h55; e.dv = 1'b1; mst = M_RX; end
                        else begin e.rxd = 8'h0E; e.er = 1'b1; mst = M_WK; end
                    end
                    M_RX: begin
                        if (tdel) mst = M_TR;
                        else if (comma) begin e.dv = 1'b1; e.er = 1'b1; mst = M_RK; end
                        else if (acc && !kk) begin e.rxd = o; e.dv = 1'b1; end
                        else begin e.dv = 1'b1; e.er = 1'b1; end
                    end
                    default: begin
                        if (rdel) mst = M_TR;
                        else if (comma && even) mst = M_RK;
                        else mst = M_WK;
                    end
                endcase
                mrd = mrd ^ ($countones(c) != 5);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [9:0] c, input bit sync, input bit rst);
        @(negedge clk);
        reset       = rst;
        sync_status = sync;
        SUDI        = {even_flag, c};
        model(c, even_flag, sync, rst);
        if (rst || !sync) tx_rd = 1'b0;
        else              tx_rd = tx_rd ^ ($countones(c) != 5);
        even_flag = ~even_flag;
    endtask

    task automatic send_oct(input logic [7:0] o, input bit k);
        drive(enc10(o, k, tx_rd), 1'b1, 1'b0);
    endtask

    task automatic send_idle();
        if (!even_flag) send_oct(8'hC5, 1'b0);
        send_oct(8'hBC, 1'b1);
        send_oct(8'hC5, 1'b0);
    endtask

    // Monitor: one comparison per cycle with a pending expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (RXD === e.rxd && RX_DV === e.dv && RX_ER === e.er) begin
                    passed++;
                end else begin
                    $display("FAIL gmii_out cycle %0d: got rxd=%02h dv=%0b er=%0b, expected rxd=%02h dv=%0b er=%0b",
                             cyc, RXD, RX_DV, RX_ER, e.rxd, e.dv, e.er);
                end
            end
        end
    end

    initial begin
        int guard;
        for (int v = 0; v < 256; v++) add_entry(8'(v), 1'b0);
        add_entry(8'hBC, 1'b1);
        add_entry(8'hFB, 1'b1);
        add_entry(8'hFD, 1'b1);
        add_entry(8'hF7, 1'b1);

        // Reset takes priority over sync and code group
        repeat (3) drive(10'b0011111010, 1'b1, 1'b1);
        even_flag = 1'b1;

        // Link up and idle
        send_oct(8'hC5, 1'b0);
        repeat (3) send_idle();

        // Basic frame
        send_oct(8'hFB, 1'b1);
        send_oct(8'h21, 1'b0);
        send_oct(8'h22, 1'b0);
        send_oct(8'h24, 1'b0);
        send_oct(8'hFD, 1'b1);
        send_oct(8'hF7, 1'b1);
        repeat (2) send_idle();

        // Invalid group mid-frame, then valid data
        send_oct(8'hFB, 1'b1);
        send_oct(8'h10, 1'b0);
        drive(10'b1100110011, 1'b1, 1'b0);
        send_oct(8'h33, 1'b0);
        send_oct(8'hFD, 1'b1);
        send_oct(8'hF7, 1'b1);
        repeat (2) send_idle();

        // False carrier: D27.0 after idle
        send_oct(8'h1B, 1'b0);
        repeat (2) send_idle();

        // Sync loss during a frame
        send_oct(8'hFB, 1'b1);
        send_oct(8'hA5, 1'b0);
        repeat (3) drive(enc10(8'h5A, 1'b0, tx_rd), 1'b0, 1'b0);
        send_oct(8'h5A, 1'b0);
        send_oct(8'h5A, 1'b0);
        repeat (3) send_idle();

        // D16.2 in the wrong RD column inside a frame
        send_oct(8'hFB, 1'b1);
        send_oct(8'h01, 1'b0);
        drive(enc10(8'h50, 1'b0, ~tx_rd), 1'b1, 1'b0);
        send_oct(8'h02, 1'b0);
        send_oct(8'hFD, 1'b1);
        send_oct(8'hF7, 1'b1);
        repeat (2) send_idle();

        // Sync loss on the /T/ cycle
        send_oct(8'hFB, 1'b1);
        send_oct(8'h77, 1'b0);
        drive(enc10(8'hFD, 1'b1, tx_rd), 1'b0, 1'b0);
        repeat (3) send_idle();

        // Back-to-back /S/, then early end by K28.5
        send_oct(8'hFB, 1'b1);
        send_oct(8'hFB, 1'b1);
        send_oct(8'hE7, 1'b0);
        send_oct(8'hBC, 1'b1);
        send_oct(8'hC5, 1'b0);
        repeat (2) send_idle();

        // Reset asserted mid-frame
        send_oct(8'hFB, 1'b1);
        send_oct(8'h3C, 1'b0);
        drive(enc10(8'h3C, 1'b0, tx_rd), 1'b1, 1'b1);
        drive(enc10(8'h3C, 1'b0, tx_rd), 1'b1, 1'b1);
        send_oct(8'hC5, 1'b0);
        repeat (3) send_idle();

        // Randomised frames with corruption, wrong-column groups and sync loss
        for (int p = 0; p < 250; p++) begin
            int n;
            int endk;
            n = $urandom_range(1, 3);
            repeat (n) send_idle();
            send_oct(8'hFB, 1'b1);
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                int         r;
                logic [7:0] d;
                r = $urandom_range(0, 99);
                d = 8'($urandom);
                if (r < 4)      drive(10'($urandom_range(0, 1023)), 1'b1, 1'b0);
                else if (r < 8) drive(enc10(d, 1'b0, ~tx_rd), 1'b1, 1'b0);
                else if (r < 10) drive(enc10(d, 1'b0, tx_rd), 1'b0, 1'b0);
                else            send_oct(d, 1'b0);
            end
            endk = $urandom_range(0, 2);
            if (endk == 2) begin
                send_oct(8'hBC, 1'b1);
                send_oct(8'hC5, 1'b0);
            end else begin
                send_oct(8'hFD, 1'b1);
                send_oct(8'hF7, 1'b1);
                if (endk == 1) send_oct(8'hF7, 1'b1);
            end
        end
        repeat (2) send_idle();

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
